// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX arbiter slice.
package uart_tx_pkg;

    localparam int unsigned DefaultDataWidth = 8;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StLaunch    = 2'd1,
        StWaitStart = 2'd2,
        StWaitDone  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer/serializer signal bundle around the UART TX arbiter.
// The master modport is the arbiter's view; the slave modport is its surroundings.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = uart_tx_pkg::DefaultDataWidth
);
    import uart_tx_pkg::*;

    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         tx_p_data;
    logic                          tx_data_valid;
    logic                          tx_busy;
    logic [IdW-1:0]                grant_id;
    logic                          arb_busy;
    logic                          err_timeout;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_p_data, tx_data_valid, grant_id, arb_busy, err_timeout
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_p_data, tx_data_valid, grant_id, arb_busy, err_timeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int unsigned N   = 4,
    localparam int unsigned IdW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IdW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IdW-1:0] idx,
    output logic           any_req
);

    logic           found;
    int unsigned    pos;
    logic [IdW-1:0] pos_idx;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos     = (32'(ptr) + i) % N;
            pos_idx = IdW'(pos);
            if (!found && req[pos_idx]) begin
                found        = 1'b1;
                gnt[pos_idx] = 1'b1;
                idx          = pos_idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer among NUM_REQ byte producers with round-robin grants,
// launching one DATA_VALID pulse per captured byte and tracking BUSY through the frame.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
    parameter int unsigned START_TIMEOUT = 4
) (
    input logic               CLK,
    input logic               RST,
    uart_tx_arbiter_if.master bus
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(START_TIMEOUT);

    arb_state_t            state_q, state_d;
    logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [IdW-1:0]        grant_id_q, grant_id_d;
    logic [CntW-1:0]       start_cnt_q, start_cnt_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IdW-1:0]        arb_idx;
    logic                  arb_any;
    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .any_req (arb_any)
    );

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        hold_data_d       = hold_data_q;
        grant_id_d        = grant_id_q;
        start_cnt_d       = start_cnt_q;
        bus.req_ready     = '0;
        bus.tx_data_valid = 1'b0;
        bus.err_timeout   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A BUSY seen here belongs to someone else; never launch on top of it.
                if (arb_any && !bus.tx_busy) begin
                    bus.req_ready = arb_gnt;
                    hold_data_d   = req_bytes[arb_idx];
                    grant_id_d    = arb_idx;
                    rr_ptr_d      = (arb_idx == IdW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d       = StLaunch;
                end
            end
            StLaunch: begin
                bus.tx_data_valid = 1'b1;
                start_cnt_d       = '0;
                state_d           = StWaitStart;
            end
            StWaitStart: begin
                if (bus.tx_busy) begin
                    state_d = StWaitDone;
                end else if (start_cnt_q == CntW'(START_TIMEOUT - 1)) begin
                    // Byte is dropped, not retried.
                    bus.err_timeout = 1'b1;
                    state_d         = StIdle;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            hold_data_q <= '0;
            grant_id_q  <= '0;
            start_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_data_q <= hold_data_d;
            grant_id_q  <= grant_id_d;
            start_cnt_q <= start_cnt_d;
        end
    end

    assign bus.tx_p_data = hold_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.arb_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 4;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    uart_tx_arbiter_if #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .DATA_WIDTH    (DW),
        .START_TIMEOUT (TO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;

    // Reference: first set request at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (v[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_pdata"}, 32'(bus.tx_p_data), 32'd0);
        check({tag, "_dv"}, 32'(bus.tx_data_valid), 32'd0);
        check({tag, "_gid"}, 32'(bus.grant_id), 32'd0);
        check({tag, "_abusy"}, 32'(bus.arb_busy), 32'd0);
        check({tag, "_err"}, 32'(bus.err_timeout), 32'd0);
    endtask

    // Grant cycle G followed by the launch cycle G+1.
    task automatic grant_launch(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                                output int w, output logic [DW-1:0] b);
        tick();
        bus.req_valid = v;
        bus.req_data  = d;
        bus.tx_busy   = 1'b0;
        sample();
        w = pick(v, model_ptr);
        b = DW'(d >> (w * DW));
        check("grant_ready", 32'(bus.req_ready), 32'(1 << w));
        check("grant_dv", 32'(bus.tx_data_valid), 32'd0);
        check("grant_abusy", 32'(bus.arb_busy), 32'd0);
        model_ptr = (w + 1) % N;
        tick();
        sample();
        check("launch_dv", 32'(bus.tx_data_valid), 32'd1);
        check("launch_data", 32'(bus.tx_p_data), 32'(b));
        check("launch_gid", 32'(bus.grant_id), 32'(w));
        check("launch_ready", 32'(bus.req_ready), 32'd0);
        check("launch_err", 32'(bus.err_timeout), 32'd0);
        check("launch_abusy", 32'(bus.arb_busy), 32'd1);
    endtask

    task automatic finish_frame(input int busy_len, input bit timeout, input logic [DW-1:0] b);
        if (timeout) begin
            for (int k = 1; k <= TO; k++) begin
                tick();
                sample();
                check("to_err", 32'(bus.err_timeout), 32'(k == TO));
                check("to_dv", 32'(bus.tx_data_valid), 32'd0);
                check("to_data", 32'(bus.tx_p_data), 32'(b));
                check("to_abusy", 32'(bus.arb_busy), 32'd1);
            end
        end else begin
            for (int k = 0; k < busy_len; k++) begin
                tick();
                bus.tx_busy = 1'b1;
                sample();
                check("frame_abusy", 32'(bus.arb_busy), 32'd1);
                check("frame_dv", 32'(bus.tx_data_valid), 32'd0);
                check("frame_ready", 32'(bus.req_ready), 32'd0);
                check("frame_data", 32'(bus.tx_p_data), 32'(b));
                check("frame_err", 32'(bus.err_timeout), 32'd0);
            end
            tick();
            bus.tx_busy = 1'b0;
            sample();
            check("drop_abusy", 32'(bus.arb_busy), 32'd1);
            check("drop_ready", 32'(bus.req_ready), 32'd0);
        end
    endtask

    task automatic idle_busy(input logic [N-1:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            bus.req_valid = v;
            bus.tx_busy   = 1'b1;
            sample();
            check("ibusy_ready", 32'(bus.req_ready), 32'd0);
            check("ibusy_dv", 32'(bus.tx_data_valid), 32'd0);
            check("ibusy_abusy", 32'(bus.arb_busy), 32'd0);
        end
    endtask

    initial begin
        int               w;
        logic [DW-1:0]    b;
        logic [N-1:0]     v;
        logic [N*DW-1:0]  d;
        logic [N-1:0]     after_v [2];

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        RST = 1'b1;
        #1 RST = 1'b0;
        sample();
        sample();
        check_all_zero("reset");
        tick();
        RST = 1'b1;

        // Strict round-robin with all requesters active.
        for (int f = 0; f < 8; f++) begin
            grant_launch(4'b1111, 32'h13121110, w, b);
            check("rr_gid", 32'(bus.grant_id), 32'(f % 4));
            check("rr_byte", 32'(bus.tx_p_data), 32'(8'h10 + (f % 4)));
            finish_frame(3, 1'b0, b);
        end

        // Single grant with an 11-cycle frame.
        grant_launch(4'b0100, 32'h00A50000, w, b);
        check("sg_gid", 32'(bus.grant_id), 32'd2);
        check("sg_data", 32'(bus.tx_p_data), 32'hA5);
        finish_frame(11, 1'b0, b);
        tick();
        bus.req_valid = '0;
        sample();
        check("sg_idle_abusy", 32'(bus.arb_busy), 32'd0);

        // Wrap past the top index, skipping idle requesters.
        grant_launch(4'b0011, 32'h0000BBAA, w, b);
        check("wrap_gid0", 32'(bus.grant_id), 32'd0);
        finish_frame(2, 1'b0, b);
        grant_launch(4'b0011, 32'h0000BBAA, w, b);
        check("wrap_gid1", 32'(bus.grant_id), 32'd1);
        finish_frame(2, 1'b0, b);

        // BUSY never rises: timeout, then a normal frame.
        grant_launch(4'b0001, 32'h0000005A, w, b);
        finish_frame(0, 1'b1, b);
        grant_launch(4'b0010, 32'h00006600, w, b);
        check("post_to_gid", 32'(bus.grant_id), 32'd1);
        finish_frame(4, 1'b0, b);

        // Foreign BUSY in IDLE holds off the grant.
        idle_busy(4'b0001, 4);
        grant_launch(4'b0001, 32'h00000077, w, b);
        check("ibusy_gid", 32'(bus.grant_id), 32'd0);
        finish_frame(2, 1'b0, b);

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            d = $urandom;
            if ($urandom_range(0, 4) == 0) idle_busy(v, int'($urandom_range(1, 3)));
            if ($urandom_range(0, 3) == 0) begin
                tick();
                bus.req_valid = '0;
                bus.tx_busy   = 1'b0;
                sample();
                check("idle_ready", 32'(bus.req_ready), 32'd0);
                check("idle_abusy", 32'(bus.arb_busy), 32'd0);
            end
            grant_launch(v, d, w, b);
            if ($urandom_range(0, 1) == 1) bus.req_valid = N'($urandom);
            finish_frame(int'($urandom_range(1, 12)), ($urandom_range(0, 5) == 0), b);
        end

        // Reset during WAIT_DONE; pointer must come back at 0.
        after_v[0] = 4'b1000;
        after_v[1] = 4'b1001;
        for (int r = 0; r < 2; r++) begin
            grant_launch(4'b0100, 32'h00C30000, w, b);
            for (int k = 0; k < 3; k++) begin
                tick();
                bus.tx_busy = 1'b1;
            end
            bus.req_valid = '0;
            #2 RST = 1'b0;
            bus.tx_busy = 1'b0;
            #1;
            check_all_zero("midrst");
            tick();
            tick();
            RST = 1'b1;
            model_ptr = 0;
            grant_launch(after_v[r], 32'h44332211, w, b);
            check("rst_gid", 32'(bus.grant_id), (r == 0) ? 32'd3 : 32'd0);
            finish_frame(2, 1'b0, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
